// File: rtl/fir_mac_sched_if.sv
// Stream, coefficient-load and shared-adder signals of fir_mac_sched.
// master = sample source / consumer / adder side, slave = the filter.
interface fir_mac_sched_if #(
    parameter int N    = 32,
    parameter int TAPS = 8
);
    localparam int AW = ($clog2(TAPS) < 1) ? 1 : $clog2(TAPS);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [N-1:0]  coef_data;
    logic [N-1:0]  add_a;
    logic [N-1:0]  add_b;
    logic [N-1:0]  add_res;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data, add_res, out_ready,
        input  in_ready, add_a, add_b, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data, add_res, out_ready,
        output in_ready, add_a, add_b, out_valid, out_data
    );
endinterface

// File: rtl/fir_mac_sched.sv
// Sequential FIR: one multiply-accumulate per cycle through an external shared adder.
// Define FIR_SAT_EN to saturate the accumulator on signed overflow instead of wrapping.
module fir_mac_sched #(
    parameter int N    = 32,
    parameter int TAPS = 8
) (
    input  logic             clk,
    input  logic             rst,
    fir_mac_sched_if.slave   bus,
    output logic             busy
);
    localparam int AW = ($clog2(TAPS) < 1) ? 1 : $clog2(TAPS);
    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);
    localparam logic [AW:0]   TAPS_W   = (AW + 1)'(TAPS);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                state_reg;
    state_t                state_next;
    logic signed [N-1:0]   x_reg    [TAPS];
    logic signed [N-1:0]   coef_reg [TAPS];
    logic [N-1:0]          acc_reg;
    logic [N-1:0]          acc_next;
    logic [AW-1:0]         idx_reg;
    logic signed [2*N-1:0] prod;
    logic                  accept;
    logic                  coef_hit;
    logic                  unused_prod_hi;

    // Full-width signed product; only the low N bits feed the adder.
    assign prod           = (2*N)'(coef_reg[idx_reg]) * (2*N)'(x_reg[idx_reg]);
    assign unused_prod_hi = ^prod[2*N-1:N];

    assign accept   = (state_reg == IDLE) && bus.in_valid;
    assign coef_hit = (state_reg == IDLE) && bus.coef_we && ({1'b0, bus.coef_addr} < TAPS_W);

`ifdef FIR_SAT_EN
    localparam logic [N-1:0] ACC_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] ACC_MIN = {1'b1, {(N-1){1'b0}}};
    logic ovf;

    always_comb begin
        ovf      = (bus.add_a[N-1] == bus.add_b[N-1]) && (bus.add_res[N-1] != bus.add_a[N-1]);
        acc_next = bus.add_res;
        if (ovf) begin
            acc_next = bus.add_a[N-1] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    always_comb begin
        acc_next = bus.add_res;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid)       state_next = MAC;
            MAC:     if (idx_reg == LAST_IDX) state_next = DONE;
            DONE:    if (bus.out_ready)      state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    // Handshake outputs are gated by rst so nothing is offered during reset.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        busy          = 1'b0;
        bus.add_a     = acc_reg;
        bus.add_b     = '0;
        if (!rst) begin
            case (state_reg)
                IDLE: bus.in_ready = 1'b1;
                MAC: begin
                    busy      = 1'b1;
                    bus.add_b = prod[N-1:0];
                end
                DONE: begin
                    busy          = 1'b1;
                    bus.out_valid = 1'b1;
                    bus.out_data  = acc_reg;
                end
                default: ;
            endcase
        end
    end

    // A coefficient write and a sample accept in the same cycle both land
    // at this edge, so the first MAC cycle already sees the new coefficient.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
            idx_reg <= '0;
            for (int k = 0; k < TAPS; k++) begin
                x_reg[k]    <= '0;
                coef_reg[k] <= '0;
            end
        end else begin
            if (coef_hit) begin
                coef_reg[bus.coef_addr] <= bus.coef_data;
            end
            if (accept) begin
                x_reg[0] <= bus.in_data;
                for (int k = 1; k < TAPS; k++) begin
                    x_reg[k] <= x_reg[k-1];
                end
                acc_reg <= '0;
                idx_reg <= '0;
            end else if (state_reg == MAC) begin
                acc_reg <= acc_next;
                idx_reg <= idx_reg + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fir_mac_sched.sv
// Scoreboard bench for fir_mac_sched (TAPS=4, N=32): directed scenarios plus random traffic.
module tb_fir_mac_sched;
    localparam int N    = 32;
    localparam int TAPS = 4;
    localparam int AW   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    fir_mac_sched_if #(.N(N), .TAPS(TAPS)) bus ();

    fir_mac_sched #(.N(N), .TAPS(TAPS)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    bit rand_bp   = 1'b0;
    bit rand_bit  = 1'b0;
    bit ready_fix = 1'b1;

    assign bus.add_res   = bus.add_a + bus.add_b;
    assign bus.out_ready = rand_bp ? rand_bit : ready_fix;

    always @(posedge clk) begin
        #2;
        rand_bit = 1'($urandom_range(0, 1));
    end

    int checks = 0;
    int errors = 0;
    logic [N-1:0]        exp_q[$];
    logic signed [N-1:0] xm [TAPS];
    logic signed [N-1:0] cm [TAPS];

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    // Reference: y = sum over k of coef[k]*x[k], each product truncated to N bits,
    // accumulated in order k=0..TAPS-1 with wrap (or clamp when saturating).
    function automatic logic [N-1:0] model_result();
        logic signed [N-1:0] acc;
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            longint p;
            logic [N-1:0] lo;
            p  = longint'(cm[k]) * longint'(xm[k]);
            lo = p[N-1:0];
`ifdef FIR_SAT_EN
            begin
                longint t;
                t = longint'(acc) + longint'($signed(lo));
                if (t > 64'sd2147483647)  t = 64'sd2147483647;
                if (t < -64'sd2147483648) t = -64'sd2147483648;
                acc = t[N-1:0];
            end
`else
            acc = acc + $signed(lo);
`endif
        end
        return acc;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < TAPS; k++) begin
            xm[k] = '0;
            cm[k] = '0;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got %h expected none", bus.out_data);
            end else begin
                chk("out_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [AW-1:0] a, input logic [N-1:0] d);
        bus.coef_we   = 1'b1;
        bus.coef_addr = a;
        bus.coef_data = d;
        tick();
        bus.coef_we = 1'b0;
        cm[a] = d;
    endtask

    task automatic send(input logic [N-1:0] d, input bit we, input logic [AW-1:0] a,
                        input logic [N-1:0] cd);
        int n;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.coef_we   = we;
        bus.coef_addr = a;
        bus.coef_data = cd;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got in_ready=0 expected 1 within 200 cycles");
        end else begin
            tick();
            if (we) cm[a] = cd;
            for (int k = TAPS - 1; k > 0; k--) xm[k] = xm[k-1];
            xm[0] = d;
            exp_q.push_back(model_result());
        end
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
    endtask

    task automatic send_s(input logic [N-1:0] d);
        send(d, 1'b0, '0, '0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        model_clear();

        // Reset state
        tick(); tick(); tick();
        chk("rst_in_ready",  N'(bus.in_ready),  '0);
        chk("rst_out_valid", N'(bus.out_valid), '0);
        chk("rst_busy",      N'(busy),          '0);
        chk("rst_out_data",  bus.out_data,      '0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", N'(bus.in_ready), 32'd1);

        // Impulse response with latency check on the first sample
        for (int k = 0; k < TAPS; k++) write_coef(AW'(k), N'(k + 1));
        send_s(32'd1);
        for (int c = 1; c <= TAPS + 1; c++) begin
            chk("lat_in_ready",  N'(bus.in_ready),  '0);
            chk("lat_out_valid", N'(bus.out_valid), N'(c == TAPS + 1));
            tick();
        end
        for (int i = 0; i < 4; i++) send_s('0);
        wait_drain();

        // Backpressure: result held stable while out_ready is low
        ready_fix = 1'b0;
        send_s(32'd7);
        begin
            int n;
            logic [N-1:0] e;
            e = exp_q[$];
            n = 0;
            while (!bus.out_valid && n < 50) begin
                tick();
                n++;
            end
            for (int c = 0; c < 10; c++) begin
                chk("bp_out_valid", N'(bus.out_valid), 32'd1);
                chk("bp_out_data",  bus.out_data,      e);
                chk("bp_in_ready",  N'(bus.in_ready),  '0);
                tick();
            end
        end
        ready_fix = 1'b1;
        tick();
        chk("bp_return_idle", N'(bus.in_ready), 32'd1);

        // Overflow on a cleared delay line
        for (int i = 0; i < TAPS; i++) send_s('0);
        wait_drain();
        write_coef(2'd0, 32'h7FFF_FFFF);
        write_coef(2'd1, 32'd1);
        write_coef(2'd2, 32'd0);
        write_coef(2'd3, 32'd0);
        send_s(32'd1);
        send_s(32'd1);
        wait_drain();

        // Coefficient write during MAC is ignored; in IDLE it takes effect
        for (int k = 0; k < TAPS; k++) write_coef(AW'(k), N'(k + 1));
        send_s(32'd3);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'd0;
        bus.coef_data = 32'd9;
        tick(); tick();
        bus.coef_we = 1'b0;
        wait_drain();
        write_coef(2'd0, 32'd9);
        send_s(32'd2);
        send(32'd5, 1'b1, 2'd1, 32'd20);
        wait_drain();

        // Reset in the middle of MAC aborts the result
        send_s(32'd5);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("abort_busy",     N'(busy),          '0);
        chk("abort_in_ready", N'(bus.in_ready),  '0);
        chk("abort_out_data", bus.out_data,      '0);
        tick();
        rst = 1'b0;
        model_clear();
        void'(exp_q.pop_back());
        #1;
        chk("abort_in_ready_after", N'(bus.in_ready), 32'd1);
        for (int c = 0; c < TAPS + 4; c++) begin
            chk("abort_no_out", N'(bus.out_valid), '0);
            tick();
        end
        for (int k = 0; k < TAPS; k++) write_coef(AW'(k), N'(k + 1));
        send_s(32'd1);
        wait_drain();

        // Random traffic with random backpressure and coefficient writes
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] d;
            logic [N-1:0] cd;
            bit we;
            logic [AW-1:0] a;
            d  = $urandom;
            cd = $urandom;
            we = ($urandom_range(0, 3) == 0);
            a  = AW'($urandom_range(0, TAPS - 1));
            send(d, we, a, cd);
            if ($urandom_range(0, 3) == 0) begin
                bus.coef_we   = 1'b1;
                bus.coef_addr = AW'($urandom_range(0, TAPS - 1));
                bus.coef_data = $urandom;
                tick();
                bus.coef_we = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 6)) tick();
            end
        end
        wait_drain();
        rand_bp = 1'b0;
        chk("queue_empty", N'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
